// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit: data width, op encodings and
// response-buffer occupancy states.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ADD_OP = 2'd0,
        SUB_OP = 2'd1,
        XOR_OP = 2'd2,
        SLT_OP = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response buffer for alu_exec_unit: DEPTH entries of WIDTH bits, in-order,
// with ready/valid derived purely from registered occupancy state.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop_ready,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fifo_state_e      r_state;

    logic [CNT_W-1:0] w_count_nxt;
    fifo_state_e      w_state_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_state != FIFO_FULL);
    assign w_pop  = i_pop_ready && (r_state != FIFO_EMPTY);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end

        if (w_count_nxt == '0) begin
            w_state_nxt = FIFO_EMPTY;
        end else if (w_count_nxt == CNT_FULL) begin
            w_state_nxt = FIFO_FULL;
        end else begin
            w_state_nxt = FIFO_PARTIAL;
        end
    end

    // Storage is cleared on reset so the response outputs read as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= FIFO_EMPTY;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_ready = (r_state != FIFO_FULL);
    assign o_valid = (r_state != FIFO_EMPTY);
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: add/sub/xor/slt with tagged, buffered, in-order responses.
// Define ALU_EXEC_OVF_EN to add the per-response signed-overflow flag rsp_ovf.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_eq,
    output logic [TAG_W-1:0]  rsp_tag,
`ifdef ALU_EXEC_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic [15:0]       op_count
);

`ifdef ALU_EXEC_OVF_EN
    localparam int unsigned ENTRY_W = DATA_W + 1 + TAG_W + 1;
`else
    localparam int unsigned ENTRY_W = DATA_W + 1 + TAG_W;
`endif

    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_diff;
    logic [DATA_W-1:0]  w_result;
    logic               w_eq;
    logic               w_lt;
    logic               w_accept;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_rsp_entry;
    logic [15:0]        r_op_count;

    assign w_sum    = req_a + req_b;
    assign w_diff   = req_a - req_b;
    assign w_eq     = (req_a == req_b);
    assign w_lt     = ($signed(req_a) < $signed(req_b));
    assign w_accept = req_valid && req_ready;

    always_comb begin
        w_result = '0;
        case (alu_op_e'(req_op))
            ADD_OP:  w_result = w_sum;
            SUB_OP:  w_result = w_diff;
            XOR_OP:  w_result = req_a ^ req_b;
            SLT_OP:  w_result = {{(DATA_W-1){1'b0}}, w_lt};
            default: w_result = '0;
        endcase
    end

`ifdef ALU_EXEC_OVF_EN
    logic w_ovf;

    // Overflow: operands' signs make overflow possible and the result sign flipped.
    always_comb begin
        w_ovf = 1'b0;
        case (alu_op_e'(req_op))
            ADD_OP:  w_ovf = (req_a[DATA_W-1] == req_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != req_a[DATA_W-1]);
            SUB_OP:  w_ovf = (req_a[DATA_W-1] != req_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != req_a[DATA_W-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    assign w_entry = {w_result, w_eq, req_tag, w_ovf};
    assign {rsp_result, rsp_eq, rsp_tag, rsp_ovf} = w_rsp_entry;
`else
    assign w_entry = {w_result, w_eq, req_tag};
    assign {rsp_result, rsp_eq, rsp_tag} = w_rsp_entry;
`endif

    alu_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_accept),
        .i_data      (w_entry),
        .i_pop_ready (rsp_ready),
        .o_ready     (req_ready),
        .o_valid     (rsp_valid),
        .o_data      (w_rsp_entry)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op_count <= '0;
        end else if (w_accept) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (DEPTH=2, TAG_W=4).
// Overflow checks are included when ALU_EXEC_OVF_EN is defined.
module tb_alu_exec_unit;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned DEPTH = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_eq;
    logic [TAG_W-1:0]  rsp_tag;
    logic [15:0]       op_count;
`ifdef ALU_EXEC_OVF_EN
    logic              rsp_ovf;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_eq     (rsp_eq),
        .rsp_tag    (rsp_tag),
`ifdef ALU_EXEC_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string nm, input logic [31:0] res, input logic eq,
                              input logic [TAG_W-1:0] tag);
        check({nm, "_valid"},  32'(rsp_valid), 32'd1);
        check({nm, "_result"}, rsp_result, res);
        check({nm, "_eq"},     32'(rsp_eq), 32'(eq));
        check({nm, "_tag"},    32'(rsp_tag), 32'(tag));
    endtask

    logic [31:0] slt_a   [8] = '{32'd14, 32'd32, 32'hFFFF_FFF2, 32'hFFFF_FFE0,
                                 32'd14, 32'hFFFF_FFE0, 32'hFFFF_FFF2, 32'hFFFF_FFF2};
    logic [31:0] slt_b   [8] = '{32'd32, 32'd14, 32'hFFFF_FFE0, 32'hFFFF_FFF2,
                                 32'hFFFF_FFE0, 32'd14, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] slt_res [8] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    logic        slt_eq  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_op_count",  32'(op_count), 32'd0);
        check("rst_result",    rsp_result, 32'd0);
        check("rst_eq",        32'(rsp_eq), 32'd0);
        check("rst_tag",       32'(rsp_tag), 32'd0);
        reset_n = 1'b1;

        issue(2'd0, 32'd10, 32'd14, 4'd3);
        expect_rsp("add", 32'd24, 1'b0, 4'd3);
        check("add_op_count", 32'(op_count), 32'd1);

        issue(2'd1, 32'd10, 32'd14, 4'd4);
        expect_rsp("sub", 32'hFFFF_FFFC, 1'b0, 4'd4);

        issue(2'd2, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 4'd5);
        expect_rsp("xor", 32'hA5A5_A5A5, 1'b0, 4'd5);

        for (int i = 0; i < 8; i++) begin
            issue(2'd3, slt_a[i], slt_b[i], TAG_W'(i + 6));
            expect_rsp($sformatf("slt%0d", i), slt_res[i], slt_eq[i], TAG_W'(i + 6));
        end
        tick();
        check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        check("drain_op_count",  32'(op_count), 32'd11);

        // Backpressure: two accepts fill the buffer, third request must wait.
        rsp_ready = 1'b0;
        issue(2'd0, 32'd1, 32'd1, 4'd1);
        expect_rsp("stall1", 32'd2, 1'b1, 4'd1);
        check("stall1_req_ready", 32'(req_ready), 32'd1);
        issue(2'd0, 32'd2, 32'd2, 4'd2);
        check("full_req_ready", 32'(req_ready), 32'd0);
        expect_rsp("full_head", 32'd2, 1'b1, 4'd1);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'd3;
        req_b     = 32'd3;
        req_tag   = 4'd3;
        tick();
        check("held_req_ready", 32'(req_ready), 32'd0);
        expect_rsp("held_head", 32'd2, 1'b1, 4'd1);
        check("held_op_count", 32'(op_count), 32'd13);
        rsp_ready = 1'b1;
        #1;
        check("nobypass_req_ready", 32'(req_ready), 32'd0);
        tick();
        expect_rsp("order2", 32'd4, 1'b1, 4'd2);
        check("order2_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        expect_rsp("order3", 32'd6, 1'b1, 4'd3);
        check("order3_op_count", 32'(op_count), 32'd14);
        tick();
        check("order_drain_valid", 32'(rsp_valid), 32'd0);

        // Mid-operation reset discards buffered responses.
        rsp_ready = 1'b0;
        issue(2'd0, 32'd5, 32'd6, 4'd7);
        issue(2'd0, 32'd7, 32'd8, 4'd8);
        check("prerst_req_ready", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_op_count",  32'(op_count), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_result",    rsp_result, 32'd0);
        check("midrst_tag",       32'(rsp_tag), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);

        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'd1;
        req_b     = 32'd2;
        req_tag   = 4'd9;
        repeat (65535) tick();
        check("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
        tick();
        req_valid = 1'b0;
        check("wrap_zero", 32'(op_count), 32'd0);
        tick();
        check("wrap_drain_valid", 32'(rsp_valid), 32'd0);

`ifdef ALU_EXEC_OVF_EN
        issue(2'd0, 32'h7FFF_FFFF, 32'd1, 4'd1);
        expect_rsp("ovf_add", 32'h8000_0000, 1'b0, 4'd1);
        check("ovf_add_flag", 32'(rsp_ovf), 32'd1);
        issue(2'd1, 32'h8000_0000, 32'd1, 4'd2);
        expect_rsp("ovf_sub", 32'h7FFF_FFFF, 1'b0, 4'd2);
        check("ovf_sub_flag", 32'(rsp_ovf), 32'd1);
        issue(2'd0, 32'd10, 32'd14, 4'd3);
        expect_rsp("noovf_add", 32'd24, 1'b0, 4'd3);
        check("noovf_add_flag", 32'(rsp_ovf), 32'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the request/response tag.
REQ-002 SHALL have parameter DEPTH, default 2, response buffer entries (legal: 2..8).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit accepts request this cycle.
REQ-007 SHALL have port req_op  input  2  operation: add=0, sub=1, xor=2, slt=3.
REQ-008 SHALL have ports req_a, req_b  input  32 each  signed operands.
REQ-009 SHALL have port req_tag  input  TAG_W  opaque ID, returned unchanged.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-012 SHALL have ports rsp_result  output  32, rsp_eq  output  1 (A==B), rsp_tag  output  TAG_W.
REQ-013 SHALL have port op_count  output  16  count of accepted requests.

Function
REQ-014 SHALL accept a request on a cycle with req_valid && req_ready, and transfer a response on rsp_valid && rsp_ready.
REQ-015 SHALL compute add/sub as 32-bit two's complement (wrap, no carry out), xor bitwise, slt = 1 when A<B signed, else 0 (zero-extended to 32 bits).
REQ-016 SHALL set rsp_eq = (A==B) for every op.
REQ-017 SHALL register the result into a FIFO of DEPTH entries; an accepted request SHALL appear at rsp_valid exactly 1 cycle later when the FIFO is empty.
REQ-018 SHALL deliver responses in acceptance order; tag, result and eq of one entry SHALL remain stable while rsp_valid && !rsp_ready.
REQ-019 SHALL drive req_ready = (fill count < DEPTH) from registered state only, with no combinational path from rsp_ready or req_valid.
REQ-020 SHALL track occupancy with states EMPTY (count 0), PARTIAL (0<count<DEPTH) and FULL (count DEPTH); push-only increments, pop-only decrements, simultaneous push+pop leaves count unchanged.
REQ-021 SHALL, when FULL with rsp_ready=1, still hold req_ready=0 for that cycle (no same-cycle bypass).
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL increment op_count by 1 per accepted request, wrapping 0xFFFF->0x0000.

Reset
REQ-024 SHALL, on a clk edge with reset_n=0, set count=0, pointers=0, op_count=0, rsp_valid=0, req_ready=1 (post-reset), and rsp_result/rsp_eq/rsp_tag=0.
REQ-025 SHALL discard any buffered or in-flight responses when reset is asserted mid-operation; no request is accepted on a reset cycle.

Configuration
REQ-026 SHALL, with ALU_EXEC_OVF_EN defined, add port rsp_ovf output 1: signed overflow of add (same-sign operands, result sign differs) or sub (differing-sign operands, result sign differs from A); 0 for xor/slt; buffered per entry, reset 0.
REQ-027 SHALL, without ALU_EXEC_OVF_EN, have no rsp_ovf port and no overflow storage; all other behaviour identical.

Structure
REQ-028 SHALL take op encodings (ADD_OP, SUB_OP, XOR_OP, SLT_OP) and data width 32 from shared package alu_pkg.
REQ-029 SHALL instantiate one sub-module alu_rsp_fifo (parameterised DEPTH and entry width) holding {result, eq, tag[, ovf]}; the compute logic lives in alu_exec_unit.

Verification
REQ-030 Bench SHALL cover: add 10+14, tag 3, rsp_ready=1 -> next cycle rsp_valid=1, result 24, eq 0, tag 3, op_count 1.
REQ-031 Bench SHALL cover: sub 10-14 -> result 0xFFFFFFFC; xor 0x0F0F0F0F^0xAAAAAAAA -> 0xA5A5A5A5.
REQ-032 Bench SHALL cover slt pairs (14,32)->1, (32,14)->0, (-14,-32)->0, (-32,-14)->1, (14,-32)->0, (-32,14)->1, (-14,-14)->0 with eq=1; (-14,14) eq=0.
REQ-033 Bench SHALL cover: rsp_ready=0, back-to-back requests tags 1,2,3 -> req_ready low after 2 accepts, tag 3 held; raise rsp_ready -> responses tags 1,2,3 in order, stable while stalled.
REQ-034 Bench SHALL cover: FIFO full, reset_n=0 one cycle -> rsp_valid=0, op_count=0, req_ready=1 next cycle; 65536 accepts -> op_count wraps to 0.
REQ-035 Bench SHALL cover, with ALU_EXEC_OVF_EN: add 0x7FFFFFFF+1 -> result 0x80000000, rsp_ovf=1; sub 0x80000000-1 -> rsp_ovf=1; add 10+14 -> rsp_ovf=0.
